// File: rtl/pll_lock_reset_seq.sv
// Multi-PLL lock supervisor and per-domain reset sequencer.
// Each raw LOCK bit is synchronised and then debounced. Domain resets are released
// one index at a time with a fixed gap between releases. Any lock loss, forced
// re-sequence or enable change drops every reset, holds them for a while, and then
// starts again.
module pll_lock_reset_seq #(
  parameter int NUM_PLL     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 256,
  parameter int RELEASE_GAP = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_PLL-1:0]    pll_lock_in_i,
  input  logic [NUM_PLL-1:0]    chan_en_i,
  input  logic                  force_reseq_i,
  output logic [NUM_PLL-1:0]    rst_out_o,
  output logic [NUM_PLL-1:0]    lock_stable_o,
  output logic                  all_ready_o,
  output logic                  loss_evt_o,
  output logic [LOSS_CNT_W-1:0] loss_count_o,
  output logic [1:0]            state_o
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int GAP_W  = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IDX_W  = (NUM_PLL > 1) ? $clog2(NUM_PLL) : 1;

  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(LOCK_FILTER);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_PLL - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_HOLD      = 2'd3
  } state_t;

  logic [NUM_PLL-1:0] stable_w;

  // Per-channel synchroniser and lock debounce; runs whether or not the channel is enabled.
  for (genvar gi = 0; gi < NUM_PLL; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_W-1:0]      filt_q;
    logic                   stable_q;

    // Shift the raw lock through the synchroniser chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_in_i[gi]};
      end
    end

    // Count consecutive synced-high cycles; any low restarts the count and clears stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        filt_q   <= '0;
        stable_q <= 1'b0;
      end else if (!sync_q[SYNC_STAGES-1]) begin
        filt_q   <= '0;
        stable_q <= 1'b0;
      end else if (filt_q != FILT_MAX) begin
        filt_q <= filt_q + 1'b1;
        if (filt_q == FILT_LAST) begin
          stable_q <= 1'b1;
        end
      end
    end

    assign stable_w[gi] = stable_q;
  end

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [GAP_W-1:0]        gap_q;
  logic [HOLD_W-1:0]       hold_q;
  logic [NUM_PLL-1:0]      chan_en_q;
  logic [NUM_PLL-1:0]      rst_q;
  logic                    all_ready_q;
  logic                    loss_evt_q;
  logic [LOSS_CNT_W-1:0]   loss_cnt_q;

  logic lost_w;
  logic restart_w;
  logic idx_en_w;
  logic advance_w;

  assign lost_w    = |(chan_en_i & ~stable_w);
  assign restart_w = force_reseq_i || (chan_en_i != chan_en_q);
  assign idx_en_w  = chan_en_q[idx_q];
  assign advance_w = !idx_en_w || (gap_q == GAP_LAST);

  // Sequencer FSM: wait for locks, release resets in index order, run, hold after a restart.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_WAIT_LOCK;
      idx_q       <= '0;
      gap_q       <= '0;
      hold_q      <= '0;
      chan_en_q   <= '0;
      rst_q       <= '1;
      all_ready_q <= 1'b0;
      loss_evt_q  <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      loss_evt_q <= 1'b0;
      case (state_q)
        ST_WAIT_LOCK: begin
          rst_q       <= '1;
          all_ready_q <= 1'b0;
          chan_en_q   <= chan_en_i;
          if ((chan_en_i != '0) && !lost_w) begin
            state_q <= ST_RELEASE;
            idx_q   <= '0;
            gap_q   <= '0;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (lost_w || restart_w) begin
            // A loss wins over a simultaneous force/enable change and is the only thing counted.
            state_q     <= ST_HOLD;
            rst_q       <= '1;
            all_ready_q <= 1'b0;
            hold_q      <= '0;
            if (lost_w) begin
              loss_evt_q <= 1'b1;
              if (loss_cnt_q != '1) begin
                loss_cnt_q <= loss_cnt_q + 1'b1;
              end
            end
          end else if (state_q == ST_RELEASE) begin
            // A skipped index keeps the gap timer running so the next enabled domain
            // still releases one full gap after the previous release.
            if (idx_en_w && (gap_q == GAP_LAST)) begin
              rst_q[idx_q] <= 1'b0;
              gap_q        <= '0;
            end else if (gap_q != GAP_LAST) begin
              gap_q <= gap_q + 1'b1;
            end
            if (advance_w) begin
              if (idx_q == IDX_LAST) begin
                state_q     <= ST_RUN;
                all_ready_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end else begin
            rst_q <= ~chan_en_q;
          end
        end
        ST_HOLD: begin
          rst_q       <= '1;
          all_ready_q <= 1'b0;
          if (hold_q == HOLD_LAST) begin
            state_q <= ST_WAIT_LOCK;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_WAIT_LOCK;
          rst_q   <= '1;
        end
      endcase
    end
  end

  assign rst_out_o     = rst_q;
  assign lock_stable_o = stable_w;
  assign all_ready_o   = all_ready_q;
  assign loss_evt_o    = loss_evt_q;
  assign loss_count_o  = loss_cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with default parameters.
module tb_pll_lock_reset_seq;

  logic       clk;
  logic       rst;
  logic [3:0] pll;
  logic [3:0] chan;
  logic       frc;
  logic [3:0] rst_out;
  logic [3:0] stable;
  logic       ready;
  logic       evt;
  logic [7:0] count;
  logic [1:0] state;

  int n_pass;
  int n_total;

  pll_lock_reset_seq dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pll_lock_in_i (pll),
    .chan_en_i     (chan),
    .force_reseq_i (frc),
    .rst_out_o     (rst_out),
    .lock_stable_o (stable),
    .all_ready_o   (ready),
    .loss_evt_o    (evt),
    .loss_count_o  (count),
    .state_o       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input logic [1:0] st, input int max, input string tag);
    int k;
    k = 0;
    while (state !== st && k < max) begin
      tick();
      k++;
    end
    chk(tag, 32'(state), 32'(st));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1; pll = 4'h0; chan = 4'h0; frc = 1'b0;
    tick(); tick();
    chk("rst_rst_out", 32'(rst_out), 32'hF);
    chk("rst_stable", 32'(stable), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_evt", 32'(evt), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    rst = 1'b0;

    // 1: all locks rise together, all channels enabled
    chan = 4'hF; pll = 4'hF;
    ticks(257);
    chk("t1_stable_257", 32'(stable), 32'h0);
    tick();
    chk("t1_stable_258", 32'(stable), 32'hF);
    chk("t1_state_wait", 32'(state), 32'h0);
    tick();
    chk("t1_state_release", 32'(state), 32'h1);
    ticks(15);
    chk("t1_rst_e15", 32'(rst_out), 32'hF);
    tick();
    chk("t1_rst_e16", 32'(rst_out), 32'hE);
    ticks(16);
    chk("t1_rst_e32", 32'(rst_out), 32'hC);
    ticks(16);
    chk("t1_rst_e48", 32'(rst_out), 32'h8);
    ticks(15);
    chk("t1_ready_e63", 32'(ready), 32'h0);
    tick();
    chk("t1_rst_e64", 32'(rst_out), 32'h0);
    chk("t1_ready_e64", 32'(ready), 32'h1);
    chk("t1_state_run", 32'(state), 32'h2);

    // 3: one-cycle drop of lock 2 while running
    pll = 4'hB;
    tick();
    pll = 4'hF;
    tick(); tick();
    chk("t3_rst_edge3", 32'(rst_out), 32'h0);
    tick();
    chk("t3_rst_edge4", 32'(rst_out), 32'hF);
    chk("t3_evt", 32'(evt), 32'h1);
    chk("t3_count", 32'(count), 32'h1);
    chk("t3_state_hold", 32'(state), 32'h3);
    chk("t3_ready", 32'(ready), 32'h0);
    tick();
    chk("t3_evt_pulse_end", 32'(evt), 32'h0);
    ticks(62);
    chk("t3_hold_63", 32'(state), 32'h3);
    tick();
    chk("t3_hold_exit", 32'(state), 32'h0);
    ticks(190);
    chk("t3_refilter_258", 32'(stable), 32'hB);
    tick();
    chk("t3_refilter_259", 32'(stable), 32'hF);
    tick();
    chk("t3_reseq_release", 32'(state), 32'h1);
    ticks(64);
    chk("t3_reseq_run", 32'(state), 32'h2);
    chk("t3_reseq_rst", 32'(rst_out), 32'h0);

    // 2: enable change while running -> hold without counting, then sparse release
    chan = 4'hA;
    tick();
    chk("t2_state_hold", 32'(state), 32'h3);
    chk("t2_no_evt", 32'(evt), 32'h0);
    chk("t2_count_same", 32'(count), 32'h1);
    ticks(64);
    chk("t2_wait", 32'(state), 32'h0);
    tick();
    chk("t2_release", 32'(state), 32'h1);
    ticks(16);
    chk("t2_rst_e16", 32'(rst_out), 32'hD);
    ticks(15);
    chk("t2_rst_e31", 32'(rst_out), 32'hD);
    tick();
    chk("t2_rst_e32", 32'(rst_out), 32'h5);
    chk("t2_run", 32'(state), 32'h2);
    chk("t2_ready", 32'(ready), 32'h1);

    // 5: forced re-sequence, loss+force, saturation
    frc = 1'b1; pll = 4'hE;
    tick();
    frc = 1'b0;
    chk("t5_force_hold", 32'(state), 32'h3);
    chk("t5_force_no_evt", 32'(evt), 32'h0);
    chk("t5_force_count", 32'(count), 32'h1);
    chk("t5_force_rst", 32'(rst_out), 32'hF);
    wait_state(2'd0, 80, "t5_force_wait");
    wait_state(2'd2, 200, "t5_force_run");
    chk("t5_run_rst", 32'(rst_out), 32'h5);
    chan = 4'hB; frc = 1'b1;
    tick();
    frc = 1'b0;
    chk("t5_lf_hold", 32'(state), 32'h3);
    chk("t5_lf_evt", 32'(evt), 32'h1);
    chk("t5_lf_count", 32'(count), 32'h2);
    tick();
    chk("t5_lf_evt_end", 32'(evt), 32'h0);
    for (int i = 0; i < 253; i++) begin
      chan = 4'hA;
      wait_state(2'd0, 80, "t5_loop_wait");
      tick();
      chk("t5_loop_release", 32'(state), 32'h1);
      chan = 4'hB;
      tick();
    end
    chk("t5_count_255", 32'(count), 32'hFF);
    chan = 4'hA;
    wait_state(2'd0, 80, "t5_sat_wait");
    tick();
    chan = 4'hB;
    tick();
    chk("t5_sat_evt", 32'(evt), 32'h1);
    chk("t5_sat_count", 32'(count), 32'hFF);
    chk("t5_sat_hold", 32'(state), 32'h3);

    // 4: 100-cycle glitch during filtering of lock 0
    chan = 4'hA; pll = 4'hF;
    ticks(150);
    chk("t4_pre_glitch", 32'(stable[0]), 32'h0);
    pll = 4'hE;
    ticks(100);
    pll = 4'hF;
    ticks(257);
    chk("t4_stable_257", 32'(stable[0]), 32'h0);
    tick();
    chk("t4_stable_258", 32'(stable[0]), 32'h1);
    chk("t4_state_run", 32'(state), 32'h2);

    // 6: reset asserted mid-release
    frc = 1'b1;
    tick();
    frc = 1'b0;
    wait_state(2'd0, 80, "t6_wait");
    tick();
    chk("t6_release", 32'(state), 32'h1);
    ticks(5);
    rst = 1'b1;
    #1;
    chk("t6_rst_out", 32'(rst_out), 32'hF);
    chk("t6_state", 32'(state), 32'h0);
    chk("t6_count", 32'(count), 32'h0);
    chk("t6_ready", 32'(ready), 32'h0);
    chk("t6_stable", 32'(stable), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
